// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared states, constants and divisor helper for UART8 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic int calc_div(input int clk_rate, input int rate);
        return clk_rate / rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart8_transceiver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart8_transceiver_if : host byte side and serial pins of UART8   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart8_transceiver_if;

    logic       rxEn;
    logic       rxIn;
    logic       rxBusy;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxOut;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;
    logic       txBusy;
    logic       txDone;
    logic       txOut;

    modport master (
        output rxEn, rxIn, txEn, txStart, txIn,
        input  rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
    );

    modport slave (
        input  rxEn, rxIn, txEn, txStart, txIn,
        output rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_tick : divide-by-DIV counter, 1-cycle tick on wrap     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/uart8_transceiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart8_transceiver : 8N1 UART, 16x oversampled rx, baud-rate tx   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart8_transceiver
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input logic                 clk,
    input logic                 rst_n,
    uart8_transceiver_if.slave  bus
);

    localparam int RX_DIV = calc_div(CLOCK_RATE, BAUD_RATE * OVERSAMPLE);
    localparam int TX_DIV = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int SCW    = $clog2(OVERSAMPLE);

    // ---------------- receiver ----------------
    rx_state_t      rx_state_q, rx_state_d;
    logic           rx_sync1_q, rx_sync2_q;
    logic [SCW-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [7:0]     rx_out_q, rx_out_d;
    logic           rx_done_q, rx_done_d;
    logic           rx_err_q, rx_err_d;
    logic           rx_tick;

    uart_baud_tick #(.DIV(RX_DIV)) u_rx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_state_q == RX_IDLE),
        .en    (rx_state_q != RX_IDLE),
        .tick  (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_out_d   = rx_out_q;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        if (!bus.rxEn) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync2_q) begin
                        rx_state_d = RX_START;
                        rx_tcnt_d  = '0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_tcnt_d = rx_tcnt_q + SCW'(1);
                        if (rx_tcnt_q == SCW'(START_MID - 1)) begin
                            // A high line at mid-start is a glitch, not a frame
                            rx_tcnt_d  = '0;
                            rx_bit_d   = '0;
                            rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_tcnt_d = rx_tcnt_q + SCW'(1);
                        if (rx_tcnt_q == SCW'(OVERSAMPLE - 1)) begin
                            rx_shift_d[rx_bit_q] = rx_sync2_q;
                            rx_bit_d             = rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_tcnt_d = rx_tcnt_q + SCW'(1);
                        if (rx_tcnt_q == SCW'(OVERSAMPLE - 1)) begin
                            rx_state_d = RX_IDLE;
                            if (rx_sync2_q) begin
                                rx_out_d  = rx_shift_q;
                                rx_done_d = 1'b1;
                            end else begin
                                rx_err_d  = 1'b1;
                            end
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_out_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync1_q <= bus.rxIn;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_out_q   <= rx_out_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign bus.rxBusy = (rx_state_q != RX_IDLE);
    assign bus.rxDone = rx_done_q;
    assign bus.rxErr  = rx_err_q;
    assign bus.rxOut  = rx_out_q;

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_out_q, tx_out_d;
    logic       tx_done_q, tx_done_d;
    logic       tx_tick;

    uart_baud_tick #(.DIV(TX_DIV)) u_tx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tx_state_q == TX_IDLE),
        .en    (tx_state_q != TX_IDLE),
        .tick  (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.txEn && bus.txStart) begin
                    tx_shift_d = bus.txIn;
                    tx_out_d   = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_out_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_out_d   = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_out_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bus.txBusy = (tx_state_q != TX_IDLE);
    assign bus.txDone = tx_done_q;
    assign bus.txOut  = tx_out_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8_transceiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart8_transceiver : directed self-checking bench for UART8    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart8_transceiver;

    localparam int TX_BIT  = 1250;                 // 12 MHz / 9600
    localparam int RX_BIT  = 16 * 78;              // 16 * RX_DIV
    localparam int STRETCH = RX_BIT * 1075 / 1042; // +3 % bit time

    logic clk = 1'b0;
    logic rst_n;
    logic loop_en;
    logic rx_drv;

    int checks      = 0;
    int failures    = 0;
    int rx_done_cnt = 0;
    int rx_err_cnt  = 0;
    int tx_done_cnt = 0;
    logic [7:0] rx_bytes[$];

    uart8_transceiver_if u_if ();

    assign u_if.rxIn = loop_en ? u_if.txOut : rx_drv;

    uart8_transceiver #(
        .CLOCK_RATE (12000000),
        .BAUD_RATE  (9600)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.rxDone === 1'b1) begin
            rx_done_cnt++;
            rx_bytes.push_back(u_if.rxOut);
        end
        if (u_if.rxErr === 1'b1)  rx_err_cnt++;
        if (u_if.txDone === 1'b1) tx_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame on rx_drv; counts rxBusy highs at mid-bit of start+data.
    task automatic send_rx(input logic [7:0] b, input int bitlen, input int stoplen,
                           input logic stopv, output int busy_hi);
        logic [9:0] fr;
        int len;
        fr      = {stopv, b, 1'b0};
        busy_hi = 0;
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            len    = (i == 9) ? stoplen : bitlen;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                if (i < 9 && k == len / 2 && u_if.rxBusy === 1'b1) busy_hi++;
            end
        end
        rx_drv = 1'b1;
    endtask

    task automatic tx_a5_check();
        logic [9:0] exp_bits;
        int bad;
        exp_bits     = {1'b1, 8'hA5, 1'b0};
        u_if.txIn    = 8'hA5;
        u_if.txStart = 1'b1;
        @(negedge clk);
        u_if.txStart = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < TX_BIT; k++) begin
                if (u_if.txOut !== exp_bits[b] || u_if.txBusy !== 1'b1 || u_if.txDone !== 1'b0) bad++;
                @(negedge clk);
            end
            check($sformatf("tx_bit%0d_bad_cycles", b), bad, 0);
        end
        check("tx_done_at_end", u_if.txDone, 1'b1);
        check("tx_busy_at_end", u_if.txBusy, 1'b0);
        @(negedge clk);
        check("tx_done_one_cycle", u_if.txDone, 1'b0);
        check("tx_out_idle", u_if.txOut, 1'b1);
    endtask

    task automatic wait_tx_done(input string tag);
        int n;
        n = 0;
        while (u_if.txDone !== 1'b1 && n < 13000) begin
            @(negedge clk);
            n++;
        end
        check(tag, u_if.txDone, 1'b1);
    endtask

    initial begin
        int bh;
        int done0, err0;
        logic [7:0] lb [3];
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;

        rst_n        = 1'b0;
        loop_en      = 1'b0;
        rx_drv       = 1'b1;
        u_if.rxEn    = 1'b0;
        u_if.txEn    = 1'b0;
        u_if.txStart = 1'b0;
        u_if.txIn    = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_rxBusy", u_if.rxBusy, 1'b0);
        check("rst_rxDone", u_if.rxDone, 1'b0);
        check("rst_rxErr",  u_if.rxErr,  1'b0);
        check("rst_rxOut",  u_if.rxOut,  8'h00);
        check("rst_txBusy", u_if.txBusy, 1'b0);
        check("rst_txDone", u_if.txDone, 1'b0);
        check("rst_txOut",  u_if.txOut,  1'b1);

        rst_n     = 1'b1;
        u_if.rxEn = 1'b1;
        u_if.txEn = 1'b1;
        repeat (2) @(negedge clk);

        // Rx 0x35 at nominal baud alongside Tx 0xA5 (the halves are independent)
        fork
            send_rx(8'h35, RX_BIT, RX_BIT, 1'b1, bh);
            tx_a5_check();
        join
        check("rx35_rxOut",     u_if.rxOut, 8'h35);
        check("rx35_done_cnt",  rx_done_cnt, 1);
        check("rx35_err_cnt",   rx_err_cnt,  0);
        check("rx35_busy_bits", bh, 9);
        check("tx_done_cnt",    tx_done_cnt, 1);

        // Rx 0x35 with bits 3 % long
        done0 = rx_done_cnt;
        send_rx(8'h35, STRETCH, STRETCH, 1'b1, bh);
        repeat (20) @(negedge clk);
        check("rx_slow_rxOut", u_if.rxOut, 8'h35);
        check("rx_slow_done",  rx_done_cnt - done0, 1);
        check("rx_slow_err",   rx_err_cnt, 0);

        // Framing error: 0xA5 with a low stop bit
        done0 = rx_done_cnt;
        err0  = rx_err_cnt;
        send_rx(8'hA5, RX_BIT, RX_BIT * 5 / 8, 1'b0, bh);
        repeat (700) @(negedge clk);
        check("ferr_err",    rx_err_cnt - err0, 1);
        check("ferr_done",   rx_done_cnt - done0, 0);
        check("ferr_rxOut",  u_if.rxOut, 8'h35);
        check("ferr_rxBusy", u_if.rxBusy, 1'b0);

        // Glitch of 3 oversample ticks
        err0   = rx_err_cnt;
        rx_drv = 1'b0;
        repeat (3 * 78) @(negedge clk);
        rx_drv = 1'b1;
        check("glitch_busy_high", u_if.rxBusy, 1'b1);
        repeat (700) @(negedge clk);
        check("glitch_busy_low", u_if.rxBusy, 1'b0);
        check("glitch_done",     rx_done_cnt - done0, 0);
        check("glitch_err",      rx_err_cnt - err0, 0);

        // Receiver disabled: a whole frame is ignored
        u_if.rxEn = 1'b0;
        send_rx(8'h5A, RX_BIT, RX_BIT, 1'b1, bh);
        repeat (10) @(negedge clk);
        check("rxdis_busy",  bh, 0);
        check("rxdis_done",  rx_done_cnt - done0, 0);
        check("rxdis_err",   rx_err_cnt - err0, 0);
        check("rxdis_rxOut", u_if.rxOut, 8'h35);
        u_if.rxEn = 1'b1;

        // Loopback, three back-to-back frames
        loop_en = 1'b1;
        done0   = rx_done_cnt;
        rx_bytes.delete();
        @(negedge clk);
        u_if.txIn    = lb[0];
        u_if.txStart = 1'b1;
        @(negedge clk);
        u_if.txStart = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wait_tx_done($sformatf("lb_txdone%0d", i - 1));
            if (i < 3) begin
                u_if.txIn    = lb[i];
                u_if.txStart = 1'b1;
                @(negedge clk);
                u_if.txStart = 1'b0;
                check($sformatf("lb_restart%0d", i), u_if.txBusy, 1'b1);
            end
        end
        check("lb_done_cnt", rx_done_cnt - done0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lb_byte%0d", i),
                  (rx_bytes.size() > i) ? {24'h0, rx_bytes[i]} : 32'hDEAD, {24'h0, lb[i]});
        end

        // Reset mid-frame
        u_if.txIn    = 8'hC3;
        u_if.txStart = 1'b1;
        @(negedge clk);
        u_if.txStart = 1'b0;
        repeat (2000) @(negedge clk);
        check("mid_txBusy", u_if.txBusy, 1'b1);
        check("mid_rxBusy", u_if.rxBusy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_rxBusy", u_if.rxBusy, 1'b0);
        check("arst_rxOut",  u_if.rxOut,  8'h00);
        check("arst_txBusy", u_if.txBusy, 1'b0);
        check("arst_txOut",  u_if.txOut,  1'b1);
        check("arst_rxDone", u_if.rxDone, 1'b0);
        check("arst_rxErr",  u_if.rxErr,  1'b0);
        check("arst_txDone", u_if.txDone, 1'b0);
        done0 = rx_done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        check("post_rst_txOut",  u_if.txOut, 1'b1);
        check("post_rst_rxBusy", u_if.rxBusy, 1'b0);
        check("post_rst_done",   rx_done_cnt - done0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
